// File: rtl/instr_fetch.sv
// Instruction fetch unit: one outstanding memory request, IDLE -> REQ -> VALID, branch redirect on accept.
// Optional macro FETCH_HALT_EN adds a halt input that parks the unit in IDLE.
module instr_fetch (
   input  logic        clk,
   input  logic        reset,
   output logic        imem_req,
   output logic [63:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] instr,
   output logic [63:0] instr_pc,
   output logic        instr_valid,
   input  logic        instr_ready,
   input  logic        BrTaken,
   input  logic        UncondBr,
`ifdef FETCH_HALT_EN
   input  logic        halt,
`endif
   output logic [1:0]  dbg_state
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_REQ   = 2'd1;
   localparam logic [1:0] ST_VALID = 2'd2;

   logic [1:0]  state_q, state_d;
   logic [63:0] pc_q, pc_d;
   logic [31:0] instr_q, instr_d;
   logic [63:0] instr_pc_q, instr_pc_d;
   logic [63:0] imm_ext;
   logic [63:0] next_pc;
   logic        halt_w;

`ifdef FETCH_HALT_EN
   assign halt_w = halt;
`else
   assign halt_w = 1'b0;
`endif

   // Word offset sign-extended and scaled to bytes; all PC math wraps modulo 2^64.
   always_comb begin
      if (UncondBr) begin
         imm_ext = {{36{instr_q[25]}}, instr_q[25:0], 2'b00};
      end else begin
         imm_ext = {{43{instr_q[23]}}, instr_q[23:5], 2'b00};
      end
      next_pc = BrTaken ? (instr_pc_q + imm_ext) : (instr_pc_q + 64'd4);
   end

   // Handshakes: a transfer happens on a rising edge where valid (imem_req / instr_valid)
   // and the matching ready (imem_ack / instr_ready) are both 1; the other side's signal
   // is ignored while valid is 0, and the offered payload is held until the transfer.
   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      instr_d    = instr_q;
      instr_pc_d = instr_pc_q;
      case (state_q)
         ST_IDLE: begin
            if (!halt_w) state_d = ST_REQ;
         end
         ST_REQ: begin
            if (imem_ack) begin
               instr_d    = imem_rdata;
               instr_pc_d = pc_q;
               state_d    = ST_VALID;
            end
         end
         ST_VALID: begin
            if (instr_ready) begin
               pc_d    = next_pc;
               state_d = halt_w ? ST_IDLE : ST_REQ;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         pc_q       <= 64'd0;
         instr_q    <= 32'd0;
         instr_pc_q <= 64'd0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         instr_q    <= instr_d;
         instr_pc_q <= instr_pc_d;
      end
   end

   assign imem_req    = (state_q == ST_REQ);
   assign imem_addr   = pc_q;
   assign instr_valid = (state_q == ST_VALID);
   assign instr       = instr_q;
   assign instr_pc    = instr_pc_q;
   assign dbg_state   = state_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: transaction-level model checked every cycle plus directed literal vectors.
// Build with FETCH_HALT_EN defined to add the halt scenario.
module tb_instr_fetch;

   logic        clk;
   logic        reset;
   logic        imem_req;
   logic [63:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic [31:0] instr;
   logic [63:0] instr_pc;
   logic        instr_valid;
   logic        instr_ready;
   logic        br_taken;
   logic        uncond_br;
   logic        halt;
   logic [1:0]  dbg_state;

   int n_checks = 0;
   int n_errors = 0;

   instr_fetch dut (
      .clk         (clk),
      .reset       (reset),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_ack    (imem_ack),
      .imem_rdata  (imem_rdata),
      .instr       (instr),
      .instr_pc    (instr_pc),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready),
      .BrTaken     (br_taken),
      .UncondBr    (uncond_br),
`ifdef FETCH_HALT_EN
      .halt        (halt),
`endif
      .dbg_state   (dbg_state)
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic logic [63:0] model_next(input logic [63:0] pc, input logic [31:0] ins,
                                              input logic tk, input logic ub);
      longint imm;
      if (!tk) return pc + 64'd4;
      if (ub) begin
         imm = longint'(ins[25:0]);
         if (ins[25]) imm = imm - (longint'(1) << 26);
      end else begin
         imm = longint'(ins[23:5]);
         if (ins[23]) imm = imm - (longint'(1) << 19);
      end
      return pc + 64'(imm * 4);
   endfunction

   logic [63:0] exp_q[$];
   logic [31:0] m_instr;
   logic [63:0] m_pc;
   bit ack_prev, acc_prev, acc_halt, req_stall_prev, val_stall_prev, idle_prev, halt_prev, first_post;

   always @(negedge clk) begin
      if (reset) begin
         chk("rst_req", imem_req, 0);
         chk("rst_valid", instr_valid, 0);
         exp_q.delete();
         exp_q.push_back(64'd0);
         ack_prev = 0; acc_prev = 0; req_stall_prev = 0; val_stall_prev = 0;
         idle_prev = 0; first_post = 1;
      end else begin
         chk("req_valid_excl", imem_req & instr_valid, 0);
         if (first_post) chk("post_rst_idle", {imem_req, instr_valid}, 0);
         if (idle_prev) chk("idle_to_req", imem_req, !halt_prev);
         if (ack_prev) chk("fetch_latency", instr_valid, 1);
         if (acc_prev) chk("accept_next_req", imem_req, !acc_halt);
         if (req_stall_prev) chk("req_hold", imem_req, 1);
         if (val_stall_prev) chk("valid_hold", instr_valid, 1);
         if (imem_req) begin
            if (exp_q.size() == 0) chk("addr_unexpected", 1, 0);
            else chk("imem_addr", imem_addr, exp_q[0]);
         end
         if (instr_valid) begin
            chk("instr", instr, m_instr);
            chk("instr_pc", instr_pc, m_pc);
         end
         first_post     = 0;
         ack_prev       = imem_req && imem_ack;
         acc_prev       = instr_valid && instr_ready;
         acc_halt       = halt;
         req_stall_prev = imem_req && !imem_ack;
         val_stall_prev = instr_valid && !instr_ready;
         idle_prev      = !imem_req && !instr_valid;
         halt_prev      = halt;
         if (imem_req && imem_ack && exp_q.size() != 0) begin
            m_instr = imem_rdata;
            m_pc    = exp_q.pop_front();
         end
         if (instr_valid && instr_ready)
            exp_q.push_back(model_next(m_pc, m_instr, br_taken, uncond_br));
      end
   end

   // ---------------- driver tasks ----------------
   task automatic do_reset();
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
   endtask

   // Presents one instruction (rdata already set), accepts it with br/ub, then checks the next fetch address.
   task automatic run_instr(input logic br, input logic ub, input logic [31:0] nxt_data,
                            input logic nxt_ack, input logic [63:0] exp_next, input string nm);
      bit seen = 0;
      br_taken  = br;
      uncond_br = ub;
      for (int k = 0; k < 20 && !seen; k++) begin
         @(negedge clk);
         if (instr_valid) seen = 1;
         else begin @(posedge clk); #1; end
      end
      chk({nm, "_wait"}, seen, 1);
      @(posedge clk); #1;
      imem_rdata = nxt_data;
      imem_ack   = nxt_ack;
      @(negedge clk);
      chk({nm, "_req"}, imem_req, 1);
      chk(nm, imem_addr, exp_next);
      @(posedge clk); #1;
   endtask

   logic        rec_req[1:8];
   logic        rec_val[1:8];
   logic [63:0] rec_addr[1:8];
   logic [63:0] rec_pc[1:8];
   logic [31:0] rec_instr[1:8];

   // ---------------- directed stimulus ----------------
   initial begin
      reset = 1'b1; imem_ack = 1'b0; imem_rdata = 32'd0; instr_ready = 1'b0;
      br_taken = 1'b0; uncond_br = 1'b0; halt = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset_req", imem_req, 0);
      chk("reset_valid", instr_valid, 0);
      chk("reset_instr", instr, 0);
      chk("reset_instr_pc", instr_pc, 0);
      chk("reset_addr", imem_addr, 0);

      // Straight-line fetch, ack and ready tied high: 2 cycles per instruction.
      @(posedge clk); #1;
      imem_ack = 1'b1; imem_rdata = 32'h8B02_0020; instr_ready = 1'b1;
      reset = 1'b0;
      for (int c = 1; c <= 7; c++) begin
         @(negedge clk);
         rec_req[c] = imem_req; rec_val[c] = instr_valid;
         rec_addr[c] = imem_addr; rec_pc[c] = instr_pc; rec_instr[c] = instr;
      end
      for (int c = 1; c <= 7; c++) begin
         chk($sformatf("seq_req_c%0d", c), rec_req[c], (c % 2) == 0);
         chk($sformatf("seq_val_c%0d", c), rec_val[c], (c > 1) && (c % 2) == 1);
         if ((c % 2) == 0) chk($sformatf("seq_addr_c%0d", c), rec_addr[c], 64'(4 * (c / 2 - 1)));
         if (c > 1 && (c % 2) == 1) begin
            chk($sformatf("seq_pc_c%0d", c), rec_pc[c], 64'(4 * ((c - 1) / 2 - 1)));
            chk($sformatf("seq_instr_c%0d", c), rec_instr[c], 64'h8B02_0020);
         end
      end
      @(posedge clk); #1;

      // Memory stall: ack low for 3 REQ cycles at address 4.
      imem_rdata = 32'h9100_0421;
      do_reset();
      for (int c = 1; c <= 8; c++) begin
         @(negedge clk);
         rec_req[c] = imem_req; rec_val[c] = instr_valid;
         rec_addr[c] = imem_addr; rec_pc[c] = instr_pc;
         @(posedge clk); #1;
         if (c == 3) imem_ack = 1'b0;
         if (c == 6) imem_ack = 1'b1;
      end
      for (int c = 4; c <= 7; c++) begin
         chk($sformatf("stall_req_c%0d", c), rec_req[c], 1);
         chk($sformatf("stall_addr_c%0d", c), rec_addr[c], 64'h4);
      end
      chk("stall_no_early_valid", rec_val[7], 0);
      chk("stall_valid_after_ack", rec_val[8], 1);
      chk("stall_pc", rec_pc[8], 64'h4);

      // imm26 branches: forward to 0x100, then -2 words back to 0xF8.
      imem_rdata = 32'h1400_0040;
      do_reset();
      run_instr(1, 1, 32'h17FF_FFFE, 1, 64'h100, "b26_fwd");
      run_instr(1, 1, 32'hD503_201F, 1, 64'hF8, "b26_neg");

      // imm19 taken and not taken at 0x40.
      imem_rdata = 32'h1400_0010;
      do_reset();
      run_instr(1, 1, 32'hB400_0060, 1, 64'h40, "jmp_40a");
      run_instr(1, 0, 32'hD503_201F, 1, 64'h4C, "b19_taken");
      imem_rdata = 32'h1400_0010;
      do_reset();
      run_instr(1, 1, 32'hB400_0060, 1, 64'h40, "jmp_40b");
      run_instr(0, 1, 32'h1400_0008, 1, 64'h44, "b19_not_taken");

      // Decode backpressure with BrTaken toggling; only the accept-edge value counts.
      instr_ready = 1'b0;
      br_taken = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk($sformatf("hold_instr_%0d", i), instr, 32'h1400_0008);
         chk($sformatf("hold_pc_%0d", i), instr_pc, 64'h44);
         chk($sformatf("hold_noreq_%0d", i), imem_req, 0);
         @(posedge clk); #1;
         br_taken = ~br_taken;
      end
      br_taken = 1'b1; uncond_br = 1'b1; instr_ready = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      chk("hold_accept_target", imem_addr, 64'h64);
      @(posedge clk); #1;

      // Wraparound: branch to -4, then +4 wraps to 0.
      imem_rdata = 32'h17FF_FFFF;
      do_reset();
      run_instr(1, 1, 32'hD503_201F, 1, 64'hFFFF_FFFF_FFFF_FFFC, "wrap_neg");
      run_instr(0, 0, 32'hD503_201F, 1, 64'h0, "wrap_plus4");

      // Reset mid-REQ at 0x20; late ack is ignored and fetch restarts at 0.
      imem_rdata = 32'h1400_0008;
      do_reset();
      run_instr(1, 1, 32'h0, 0, 64'h20, "jmp_20");
      reset = 1'b1;
      @(negedge clk);
      chk("midreq_rst_req", imem_req, 0);
      chk("midreq_rst_valid", instr_valid, 0);
      chk("midreq_rst_addr", imem_addr, 0);
      @(posedge clk); #1;
      reset = 1'b0; imem_ack = 1'b1;
      @(negedge clk);
      chk("late_ack_ignored_req", imem_req, 0);
      chk("late_ack_ignored_valid", instr_valid, 0);
      @(negedge clk);
      chk("restart_req", imem_req, 1);
      chk("restart_addr", imem_addr, 0);
      @(posedge clk); #1;

`ifdef FETCH_HALT_EN
      imem_rdata = 32'hD503_201F; br_taken = 1'b0;
      do_reset();
      run_instr(0, 0, 32'hD503_201F, 1, 64'h4, "halt_pre0");
      run_instr(0, 0, 32'hD503_201F, 1, 64'h8, "halt_pre1");
      halt = 1'b1;
      @(posedge clk); #1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk($sformatf("halt_noreq_%0d", i), imem_req, 0);
         chk($sformatf("halt_novalid_%0d", i), instr_valid, 0);
         @(posedge clk); #1;
      end
      halt = 1'b0;
      @(negedge clk);
      chk("halt_release_idle", imem_req, 0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("halt_resume_req", imem_req, 1);
      chk("halt_resume_addr", imem_addr, 64'hC);
      @(posedge clk); #1;
`endif

      repeat (4) @(posedge clk);
      #1;
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #100000;
      n_errors++;
      $display("FAIL watchdog: got timeout expected completion");
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $fatal(1, "watchdog expired");
   end

endmodule
